// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, requests words from instruction memory and hands them to the datapath
// through an output register backed by a one-entry skid buffer. Optional macro: FETCH_PERF_CNT_EN.
module instruction_fetch #(
    parameter int                  PC_WIDTH    = 16,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    pc_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]            fetch_count
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, SKID, FLUSH} state_t;

    state_t                 state;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [PC_WIDTH-1:0]    skid_pc;
    logic [PC_WIDTH-1:0]    saved_target;
    logic                   slot_free;

    assign slot_free = !instr_valid || !stall;

    // pc only moves on a response or while no request is outstanding, so the address stays stable
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_out      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    if (branch_taken) begin
                        pc <= branch_target;
                    end
                end
                FETCH: begin
                    if (branch_taken) begin
                        instr_valid <= 1'b0;
                        if (imem_ready) begin
                            pc <= branch_target;
                        end else begin
                            state <= FLUSH;
                        end
                    end else if (imem_ready) begin
                        pc <= pc + 1'b1;
                        if (slot_free) begin
                            instr       <= imem_rdata;
                            pc_out      <= pc;
                            instr_valid <= 1'b1;
                        end else begin
                            state    <= SKID;
                            imem_req <= 1'b0;
                        end
                    end else if (slot_free) begin
                        instr_valid <= 1'b0;
                    end
                end
                SKID: begin
                    if (branch_taken) begin
                        instr_valid <= 1'b0;
                        pc          <= branch_target;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                    end else if (!stall) begin
                        instr       <= skid_instr;
                        pc_out      <= skid_pc;
                        instr_valid <= 1'b1;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                    end
                end
                FLUSH: begin
                    instr_valid <= 1'b0;
                    // a branch arriving together with the stale response is the newest target
                    if (imem_ready) begin
                        pc    <= branch_taken ? branch_target : saved_target;
                        state <= FETCH;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Skid and redirect payloads are qualified by the state register and need no reset
    always_ff @(posedge clk) begin
        if (state == FETCH && imem_ready && !branch_taken && !slot_free) begin
            skid_instr <= imem_rdata;
            skid_pc    <= pc;
        end
        if (branch_taken && (state == FETCH || state == FLUSH)) begin
            saved_target <= branch_target;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 16'h0000;
        end else if (instr_valid && !stall && !branch_taken && fetch_count != 16'hFFFF) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, reset/redirect sequences, and a random run
// checked against an instruction-stream reference model.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] key     = 16'h0000;

    instruction_fetch #(
        .PC_WIDTH    (16),
        .INSTR_WIDTH (16),
        .RESET_PC    (16'h0010)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc_out        (pc_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        ready;
        logic        branch;
        logic [15:0] target;
        logic        exp_valid;
        logic        exp_req;
        logic [15:0] exp_pc_out;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs [21];

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, memory answers with the word at the current address
    task automatic cyc(input logic s, input logic r, input logic b, input logic [15:0] t);
        @(negedge clk);
        stall         = s;
        imem_ready    = r;
        branch_taken  = b;
        branch_target = t;
        imem_rdata    = imem_addr ^ key;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        stall        = 1'b0;
        imem_ready   = 1'b0;
        branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic        s, r, b, prev_req, prev_ready;
        logic [15:0] t, prev_addr, exp_next;
        int          model_count;

        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        imem_ready    = 1'b0;
        imem_rdata    = 16'h0000;

        //            stall ready br   target    valid req  pc_out    addr
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0010};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h0011};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0011, 16'h0012};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0012, 16'h0013};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 16'h0014};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 16'h0014};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 16'h0014};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0013, 16'h0014};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0014, 16'h0015};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b1, 16'h0014, 16'h0015};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0014, 16'h0015};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0014, 16'h0200};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200, 16'h0201};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0202};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0200, 16'h0040};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h0041};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b1, 16'h0040, 16'hFFFE};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFE, 16'hFFFF};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 16'h0000};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0001};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0001};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check1 ("rst_req",   imem_req,    1'b0);
        check16("rst_addr",  imem_addr,   16'h0010);
        check1 ("rst_valid", instr_valid, 1'b0);
        check16("rst_pc_out", pc_out,     16'h0000);
        check16("rst_instr", instr,       16'h0000);
        #1;
        rst_n = 1'b1;

        // Directed table: word = address, so instr must always track pc_out
        for (int i = 0; i < 21; i++) begin
            cyc(vecs[i].stall, vecs[i].ready, vecs[i].branch, vecs[i].target);
            check1 ($sformatf("vec%0d_valid", i),  instr_valid, vecs[i].exp_valid);
            check1 ($sformatf("vec%0d_req", i),    imem_req,    vecs[i].exp_req);
            check16($sformatf("vec%0d_pc_out", i), pc_out,      vecs[i].exp_pc_out);
            check16($sformatf("vec%0d_addr", i),   imem_addr,   vecs[i].exp_addr);
            check16($sformatf("vec%0d_instr", i),  instr,       vecs[i].exp_pc_out);
        end

        // Reset pulsed mid-wait takes effect without a clock edge
        #3;
        rst_n = 1'b0;
        #1;
        check1 ("midrst_req",   imem_req,    1'b0);
        check1 ("midrst_valid", instr_valid, 1'b0);
        check16("midrst_addr",  imem_addr,   16'h0010);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        check1 ("restart_req",  imem_req,  1'b1);
        check16("restart_addr", imem_addr, 16'h0010);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        check1 ("restart_valid",  instr_valid, 1'b1);
        check16("restart_pc_out", pc_out,      16'h0010);

        // Redirect taken in IDLE right after reset
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 16'h0300);
        check16("idle_br_addr",  imem_addr,   16'h0300);
        check1 ("idle_br_valid", instr_valid, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        check16("idle_br_pc_out", pc_out, 16'h0300);
        check1 ("idle_br_vld2",  instr_valid, 1'b1);

`ifdef FETCH_PERF_CNT_EN
        // 10 accepted instructions, then a valid word dropped by a branch
        do_reset();
        repeat (12) cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        cyc(1'b0, 1'b1, 1'b1, 16'h0500);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        check16("perf_count", fetch_count, 16'd10);
`endif

        // Random run against an instruction-stream model: every handed-over word must be the
        // successor of the previous one (or the latest branch target) and carry its own memory data
        key = 16'hC3A5;
        do_reset();
        exp_next    = 16'h0010;
        model_count = 0;
        prev_req    = 1'b0;
        prev_ready  = 1'b0;
        prev_addr   = 16'h0000;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (prev_req && !prev_ready) begin
                check1 ("hold_req",  imem_req,  1'b1);
                check16("hold_addr", imem_addr, prev_addr);
            end
            s = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 5);
            t = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF)) : 16'($urandom);
            r = imem_req ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 1) == 1);
            stall         = s;
            branch_taken  = b;
            branch_target = t;
            imem_ready    = r;
            imem_rdata    = (imem_req && r) ? (imem_addr ^ key) : 16'($urandom);
            if (instr_valid && !s && !b) begin
                check16("rand_pc_out", pc_out, exp_next);
                check16("rand_instr",  instr,  pc_out ^ key);
                exp_next = pc_out + 16'd1;
                model_count++;
            end
            if (b) begin
                exp_next = t;
            end
            prev_req   = imem_req;
            prev_ready = r;
            prev_addr  = imem_addr;
        end
        @(posedge clk);
        #1;
        check1("rand_progress", model_count > 300, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        check16("rand_count", fetch_count, 16'(model_count));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly upstream of the 16-bit CPU datapath.
- Owns the program counter and issues word requests to instruction memory.
- Holds the returned 16-bit instruction in an output register together with its PC, for the datapath to decode.
- Handles datapath stalls with a one-entry skid buffer.
- Handles branch/jump redirects, including discarding a response that is already in flight.

## Interface
Parameters:
- PC_WIDTH, 16, width of PC and instruction-memory address (word-addressed)
- INSTR_WIDTH, 16, instruction width
- RESET_PC, 16'h0000, first fetch address after reset

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  datapath cannot accept `instr` this cycle
- branch_taken  in  1  redirect request, one-cycle pulse
- branch_target  in  PC_WIDTH  redirect address, valid with branch_taken
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  PC_WIDTH  request address
- imem_ready  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  INSTR_WIDTH  instruction word
- instr  out  INSTR_WIDTH  registered instruction to the datapath
- instr_valid  out  1  `instr` and `pc_out` are valid
- pc_out  out  PC_WIDTH  address `instr` was fetched from
- fetch_count  out  16  present only with FETCH_PERF_CNT_EN

## Operation
- Reset values:
  - pc = RESET_PC, state = IDLE.
  - imem_req = 0; imem_addr = RESET_PC.
  - instr = 0, instr_valid = 0, pc_out = 0.
  - skid buffer empty; fetch_count = 0.
- slot_free = !instr_valid || !stall.
- Handover: the datapath consumes `instr` on any cycle with instr_valid && !stall.
- Memory protocol: imem_addr and imem_req stay stable from assertion until imem_ready. imem_ready is ignored while imem_req = 0.
- States:
  - IDLE: imem_req = 0. Goes to FETCH unconditionally on the next cycle.
  - FETCH: imem_req = 1, imem_addr = pc.
    - On imem_ready with slot_free: instr <= imem_rdata, pc_out <= pc, instr_valid <= 1, pc <= pc+1. Stay in FETCH.
    - On imem_ready without slot_free: skid <= {imem_rdata, pc}, pc <= pc+1, go to SKID.
    - With no imem_ready and slot_free: instr_valid <= 0.
  - SKID: imem_req = 0. When !stall: output register <= skid, instr_valid <= 1, go to FETCH.
  - FLUSH: imem_req = 1, imem_addr = old pc (the request in flight). On imem_ready: discard data, pc <= saved_target, go to FETCH.
- Branch handling (branch_taken overrides stall; in every case below instr_valid <= 0 on that edge):
  - FETCH with imem_ready in the same cycle: drop the returned data, pc <= branch_target, stay in FETCH.
  - FETCH without imem_ready: saved_target <= branch_target, go to FLUSH.
  - SKID: drop the skid contents, pc <= branch_target, go to FETCH.
  - FLUSH: saved_target <= branch_target (the latest branch wins).
  - IDLE: pc <= branch_target.
- Arithmetic: pc+1 is modulo 2^PC_WIDTH, so 16'hFFFF wraps to 16'h0000.
- Reset mid-operation: all state returns to reset values immediately. Any outstanding memory response is ignored because imem_req drops to 0.

## Timing
- rst_n deasserts before edge 0.
  - Edge 0: IDLE -> FETCH.
  - imem_req is high from the cycle after edge 0.
  - With zero-wait memory (imem_ready in the same cycle), instr_valid rises at edge 1.
- Throughput: one instruction per cycle with zero-wait memory and no stall.
- N wait cycles give N+1 cycles per instruction.
- Branch with zero-wait memory: the first target instruction is valid 1 cycle after the branch edge. This is a 1-cycle bubble.
- Branch into FLUSH: the target request starts the cycle after the in-flight response returns.
- Skid release: `instr` updates on the edge where stall is low. The next fetch request starts the following cycle.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - fetch_count port exists.
  - The counter increments on every edge where an instruction is handed to the datapath (instr_valid && !stall && !branch_taken).
  - It saturates at 16'hFFFF and resets to 0.
- Not defined: no port and no counter logic. The rest of the behaviour is identical.

## Test plan
- Reset with RESET_PC = 16'h0010 and zero-wait memory returning word = address -> instr_valid rises at edge 1. instr/pc_out then sequence 0x0010, 0x0011, 0x0012 on consecutive cycles.
- stall held 3 cycles while imem_ready = 1 -> one word goes to the skid buffer and imem_req drops. instr stays at its value. After stall falls, the next sequential word appears with no address skipped or repeated.
- Memory with 2 wait cycles and branch_taken to 0x0200 in the first wait cycle -> state FLUSH. The old response is discarded, the next imem_addr is 0x0200, and no instruction from the old path becomes valid.
- branch_taken to 0x0040 while in SKID -> skid contents dropped, instr_valid = 0 for 1 cycle, next pc_out = 0x0040.
- pc at 16'hFFFF -> pc_out 0xFFFF followed by 0x0000. rst_n pulsed low mid-wait -> imem_req = 0 and instr_valid = 0 immediately, and fetching restarts at RESET_PC.
- With FETCH_PERF_CNT_EN: 10 accepted instructions plus 1 branch-dropped word -> fetch_count = 10.
